jogador_led_decoder: RTL and testbench
======================================

# jogador_led_decoder

Output-side counterpart of the player-button encoder: takes a 3-bit player index and drives the five per-player LEDs as a one-hot pattern. The game controller loads an index and the selected player's LED blinks. When the controller confirms, the LED holds steady for a fixed time, then the block signals completion. The block sits between the game FSM and the board LEDs.

## Interface
- N_JOGADORES, 5: number of players and LEDs; legal indices are 0..N_JOGADORES-1.
- BLINK_DIV, 25000000: clock cycles per blink half-period.
- CONFIRM_CYCLES, 50000000: clock cycles the confirmed LED stays steady.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- jogador  in  3  player index to display; sampled only when carrega=1.
- carrega  in  1  single-cycle load strobe.
- confirma  in  1  single-cycle confirm strobe.
- vivos  in  N_JOGADORES  alive mask; bit i = player i alive.
- leds_jogadores  out  N_JOGADORES  LED drive; bit i lights player i.
- ocupado  out  1  high in PISCANDO and CONFIRMADO.
- concluido  out  1  one-cycle pulse at the end of CONFIRMADO.
- erro_indice  out  1  one-cycle pulse when a load is rejected.

## Operation
- Registers: state, idx (3 bits), cnt, fase.
- cnt width is $clog2 of the larger of BLINK_DIV and CONFIRM_CYCLES.
- States:
  - OCIOSO: leds_jogadores is the idle pattern (see Configuration).
  - PISCANDO: only bit idx is driven, equal to fase; all other bits are 0.
  - CONFIRMADO: only bit idx is driven, steady 1; all other bits are 0.
- Load acceptance, in any state:
  - Accepted when carrega=1, jogador < N_JOGADORES, and the player passes the alive check (Configuration).
  - On accept: idx<=jogador, cnt<=0, fase<=1, state<=PISCANDO.
  - A load during PISCANDO or CONFIRMADO aborts the current display; concluido does not fire.
- Load rejection:
  - erro_indice pulses for one cycle.
  - state, idx, cnt and fase are all unchanged.
- Blinking in PISCANDO:
  - cnt increments every cycle.
  - When cnt==BLINK_DIV-1: cnt<=0 and fase toggles.
- Confirm:
  - confirma=1 in PISCANDO gives state<=CONFIRMADO and cnt<=0.
  - confirma is ignored in OCIOSO and CONFIRMADO.
- Simultaneous carrega and confirma: carrega takes priority. confirma is dropped, even if the load is rejected.
- CONFIRMADO timing:
  - cnt increments every cycle.
  - When cnt==CONFIRM_CYCLES-1: state<=OCIOSO, cnt<=0, and concluido pulses for one cycle.
- Output encoding: outputs are decoded combinationally from the registers. LED bits above N_JOGADORES-1 do not exist.

## Timing
- Reset values: state=OCIOSO, idx=0, cnt=0, fase=0, leds_jogadores=idle pattern, ocupado=0, concluido=0, erro_indice=0.
- Reset asserted mid-operation returns to OCIOSO immediately and asynchronously; no concluido pulse.
- Accepted load at edge k: from after edge k, the selected LED is on and ocupado=1.
- Blink timing: the LED stays on for BLINK_DIV cycles, then off for BLINK_DIV cycles, and repeats.
- Confirm at edge k:
  - The LED is steady from after edge k.
  - At edge k+CONFIRM_CYCLES the block returns to OCIOSO.
  - concluido is high during the cycle after edge k+CONFIRM_CYCLES.
- erro_indice is high during the cycle following the rejecting edge.

## Configuration
- MOSTRA_VIVOS_EN defined:
  - Idle pattern = vivos.
  - A load whose index is in range but with vivos[jogador]=0 is rejected with erro_indice.
- MOSTRA_VIVOS_EN undefined:
  - Idle pattern = all zeros.
  - vivos is ignored; only the range check applies.
- In both cases vivos remains a port.

## Test plan
- Test parameters: BLINK_DIV=4, CONFIRM_CYCLES=6.
- Reset, then carrega with jogador=2 -> leds=00100 for 4 cycles, then 00000 for 4 cycles, repeating; ocupado=1.
- Load 3, then confirma -> leds=01000 steady for 6 cycles; concluido pulses once; then the idle pattern returns and ocupado=0.
- carrega with jogador=5, and separately jogador=7 -> erro_indice pulses each time; state and LEDs are unchanged.
- With MOSTRA_VIVOS_EN and vivos=10110: idle leds=10110; loading 0 -> erro_indice; loading 4 -> accepted.
- carrega with jogador=1 and confirma in the same cycle while PISCANDO on 4 -> idx=1, blinking restarts with the LED on, state stays PISCANDO.
- Assert reset during CONFIRMADO -> the idle pattern appears immediately; concluido never pulses.

Source files
------------

// File: rtl/jogador_led_decoder.sv
// rtl/jogador_led_decoder.sv - one-hot player LED decoder with blink, confirm hold and done pulse
// Optional feature macro: MOSTRA_VIVOS_EN (idle pattern shows vivos, dead players are rejected on load)
module jogador_led_decoder #(
  parameter int N_JOGADORES    = 5,
  parameter int BLINK_DIV      = 25000000,
  parameter int CONFIRM_CYCLES = 50000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             jogador,
  input  logic                   carrega,
  input  logic                   confirma,
  input  logic [N_JOGADORES-1:0] vivos,
  output logic [N_JOGADORES-1:0] leds_jogadores,
  output logic                   ocupado,
  output logic                   concluido,
  output logic                   erro_indice
);

  localparam int CNT_MAX = (BLINK_DIV > CONFIRM_CYCLES) ? BLINK_DIV : CONFIRM_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [3:0]       N_LIM        = 4'(N_JOGADORES);

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    PISCANDO   = 2'd1,
    CONFIRMADO = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [2:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             fase, fase_n;
  logic             concluido_q, concluido_n;
  logic             erro_q, erro_n;

  logic                   in_range;
  logic                   alive_ok;
  logic [N_JOGADORES-1:0] idle_pattern;

  assign in_range = ({1'b0, jogador} < N_LIM);

`ifdef MOSTRA_VIVOS_EN
  assign idle_pattern = vivos;

  // Alive check: look up the requested player's bit without indexing past the mask
  always_comb begin
    alive_ok = 1'b0;
    for (int i = 0; i < N_JOGADORES; i++) begin
      if (jogador == 3'(i)) alive_ok = vivos[i];
    end
  end
`else
  logic unused_vivos;
  assign unused_vivos = ^vivos;
  assign idle_pattern = '0;
  assign alive_ok     = 1'b1;
`endif

  // State and datapath registers; reset drops straight back to idle with no done pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= OCIOSO;
      idx         <= 3'd0;
      cnt         <= '0;
      fase        <= 1'b0;
      concluido_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      fase        <= fase_n;
      concluido_q <= concluido_n;
      erro_q      <= erro_n;
    end
  end

  // Next state: a load (accepted or not) wins over confirm and over the running counters
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    fase_n      = fase;
    concluido_n = 1'b0;
    erro_n      = 1'b0;
    if (carrega) begin
      if (in_range && alive_ok) begin
        idx_n   = jogador;
        cnt_n   = '0;
        fase_n  = 1'b1;
        state_n = PISCANDO;
      end else begin
        erro_n = 1'b1;
      end
    end else begin
      case (state)
        PISCANDO: begin
          if (confirma) begin
            state_n = CONFIRMADO;
            cnt_n   = '0;
          end else if (cnt == BLINK_LAST) begin
            cnt_n  = '0;
            fase_n = ~fase;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        CONFIRMADO: begin
          if (cnt == CONFIRM_LAST) begin
            state_n     = OCIOSO;
            cnt_n       = '0;
            concluido_n = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        OCIOSO: begin
          state_n = OCIOSO;
        end
        default: begin
          state_n = OCIOSO;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // LED decode: idle pattern when idle, otherwise only the selected player's bit
  always_comb begin
    leds_jogadores = '0;
    case (state)
      PISCANDO: begin
        for (int i = 0; i < N_JOGADORES; i++) begin
          if (idx == 3'(i)) leds_jogadores[i] = fase;
        end
      end
      CONFIRMADO: begin
        for (int i = 0; i < N_JOGADORES; i++) begin
          if (idx == 3'(i)) leds_jogadores[i] = 1'b1;
        end
      end
      default: leds_jogadores = idle_pattern;
    endcase
  end

  assign ocupado     = (state == PISCANDO) || (state == CONFIRMADO);
  assign concluido   = concluido_q;
  assign erro_indice = erro_q;

endmodule

// File: tb/tb_jogador_led_decoder.sv
// tb/tb_jogador_led_decoder.sv - scoreboard bench for jogador_led_decoder (BLINK_DIV=4, CONFIRM_CYCLES=6)
module tb_jogador_led_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] jogador = 3'd0;
  logic       carrega = 1'b0;
  logic       confirma = 1'b0;
  logic [4:0] vivos = 5'b10110;
  logic [4:0] leds_jogadores;
  logic       ocupado;
  logic       concluido;
  logic       erro_indice;

`ifdef MOSTRA_VIVOS_EN
  localparam logic [4:0] IDLE = 5'b10110;
`else
  localparam logic [4:0] IDLE = 5'b00000;
`endif

  typedef struct {
    int         id;
    logic [4:0] leds;
    logic       ocup;
    logic       conc;
    logic       erro;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   step_id = 0;

  jogador_led_decoder #(
    .N_JOGADORES(5),
    .BLINK_DIV(4),
    .CONFIRM_CYCLES(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .jogador(jogador),
    .carrega(carrega),
    .confirma(confirma),
    .vivos(vivos),
    .leds_jogadores(leds_jogadores),
    .ocupado(ocupado),
    .concluido(concluido),
    .erro_indice(erro_indice)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int id, input logic [4:0] el,
                       input logic eo, input logic ec, input logic ee);
    n_cmp++;
    if (leds_jogadores !== el || ocupado !== eo || concluido !== ec || erro_indice !== ee) begin
      n_err++;
      $display("FAIL %s step %0d: got leds=%b ocup=%b conc=%b erro=%b, want leds=%b ocup=%b conc=%b erro=%b",
               name, id, leds_jogadores, ocupado, concluido, erro_indice, el, eo, ec, ee);
    end
  endtask

  // Monitor: each cycle the outputs are valid, compare against the oldest expectation
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("seq", e.id, e.leds, e.ocup, e.conc, e.erro);
    end
  end

  task automatic step(input logic c, input logic [2:0] j, input logic f,
                      input logic [4:0] el, input logic eo, input logic ec, input logic ee);
    exp_t e;
    carrega  = c;
    jogador  = j;
    confirma = f;
    @(posedge clock);
    #1;
    step_id++;
    e.id = step_id; e.leds = el; e.ocup = eo; e.conc = ec; e.erro = ee;
    q.push_back(e);
    carrega  = 1'b0;
    confirma = 1'b0;
  endtask

  task automatic nop(input logic [4:0] el, input logic eo, input logic ec);
    step(1'b0, 3'd0, 1'b0, el, eo, ec, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (q.size() > 0) begin
      n_err++;
      n_cmp++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset", 0, IDLE, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Load 2, blink 4 on / 4 off / on again
    step(1'b1, 3'd2, 1'b0, 5'b00100, 1'b1, 1'b0, 1'b0);
    repeat (3) nop(5'b00100, 1'b1, 1'b0);
    repeat (4) nop(5'b00000, 1'b1, 1'b0);
    nop(5'b00100, 1'b1, 1'b0);
    nop(5'b00100, 1'b1, 1'b0);
    // Reject 7 mid-blink: cnt frozen for that cycle
    step(1'b1, 3'd7, 1'b0, 5'b00100, 1'b1, 1'b0, 1'b1);
    nop(5'b00100, 1'b1, 1'b0);
    nop(5'b00100, 1'b1, 1'b0);
    nop(5'b00000, 1'b1, 1'b0);

    // Load 4, then load 1 with confirm together: load wins, blink restarts on
    step(1'b1, 3'd4, 1'b0, 5'b10000, 1'b1, 1'b0, 1'b0);
    nop(5'b10000, 1'b1, 1'b0);
    step(1'b1, 3'd1, 1'b1, 5'b00010, 1'b1, 1'b0, 1'b0);
    repeat (3) nop(5'b00010, 1'b1, 1'b0);
    nop(5'b00000, 1'b1, 1'b0);

    // Load 4, confirm: steady 6 cycles, repeated confirm ignored, then done pulse
    step(1'b1, 3'd4, 1'b0, 5'b10000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 5'b10000, 1'b1, 1'b0, 1'b0);
    nop(5'b10000, 1'b1, 1'b0);
    nop(5'b10000, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b1, 5'b10000, 1'b1, 1'b0, 1'b0);
    nop(5'b10000, 1'b1, 1'b0);
    nop(5'b10000, 1'b1, 1'b0);
    nop(IDLE, 1'b0, 1'b1);
    nop(IDLE, 1'b0, 1'b0);

    // Reject 5 in idle, confirm ignored in idle
    step(1'b1, 3'd5, 1'b0, IDLE, 1'b0, 1'b0, 1'b1);
    nop(IDLE, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, IDLE, 1'b0, 1'b0, 1'b0);

`ifdef MOSTRA_VIVOS_EN
    step(1'b1, 3'd0, 1'b0, IDLE, 1'b0, 1'b0, 1'b1);
    nop(IDLE, 1'b0, 1'b0);
    step(1'b1, 3'd3, 1'b0, IDLE, 1'b0, 1'b0, 1'b1);
    nop(IDLE, 1'b0, 1'b0);
`else
    step(1'b1, 3'd0, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b0);
    nop(5'b00001, 1'b1, 1'b0);
    step(1'b1, 3'd3, 1'b0, 5'b01000, 1'b1, 1'b0, 1'b0);
    nop(5'b01000, 1'b1, 1'b0);
`endif

    // Load 2, confirm, then reset mid-hold
    step(1'b1, 3'd2, 1'b0, 5'b00100, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 5'b00100, 1'b1, 1'b0, 1'b0);
    repeat (3) nop(5'b00100, 1'b1, 1'b0);
    drain();
    #2 reset = 1'b1;
    #1 check("async_reset", 0, IDLE, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1 check("in_reset", 0, IDLE, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (8) nop(IDLE, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
